line_clear_ctrl: RTL and testbench
==================================

# line_clear_ctrl

Sequencer that performs the line-clear pass on the user playfield after a piece locks. On `start` it scans the playfield bottom-up through a single read/write row port, drops every full row, compacts the remaining rows downward, and back-fills the top with blank rows. It reports the cleared-line count to the scoring and garbage logic. It sits between the game-logic FSM and the playfield row storage, and owns that storage's write port while busy.

## Interface

Parameters:
- `ROWS`, 20, playfield rows; row 0 is the top row and row `ROWS-1` is the bottom row.
- `COLS`, 10, playfield columns.
- `RW`, `$clog2(ROWS)`, width of a row index.
- `CW`, `$clog2(ROWS+1)`, width of the line count.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a clear pass; sampled only in IDLE.
- `busy` out 1: high while a pass is in progress.
- `done` out 1: one-cycle pulse at the end of a pass.
- `lines_cleared` out CW: number of full rows removed by the last pass.
- `pf_rd_row` out RW: row index for the combinational read.
- `pf_rd_data` in 4*COLS: tiles of `pf_rd_row`, valid in the same cycle. Column c occupies bits [4c+3:4c], encoded as DisplayPkg `tile_type_t`.
- `pf_wr_en` out 1: playfield writes `pf_wr_data` to `pf_wr_row` at the next rising edge.
- `pf_wr_row` out RW: destination row index.
- `pf_wr_data` out 4*COLS: row contents to write.

## Operation

- A row is full when no column holds BLANK or GHOST. GARBAGE and I/O/T/J/L/S/Z count as filled.
- Internal pointers: `src` (row being read) and `dst` (next row to write), both RW bits wide. `src_done` flags that `src` has passed row 0.
- **IDLE:** `start`=1 moves to SCAN. On that transition: `src`=`dst`=ROWS-1, and the count clears to 0.
- **SCAN:** `pf_rd_row`=`src`.
  - Full row: count increments; `src` decrements; no write.
  - Non-full row: write `pf_rd_data` to `dst`; `src` and `dst` both decrement.
  - Exit: in the cycle where `src`=0, go to FILL if the final count (including this row) is greater than 0; otherwise go to DONE.
- **FILL:** write all-BLANK (all zero) to `dst`; `dst` decrements. In the cycle where `dst`=0, go to DONE.
- **DONE:** `done`=1 for exactly one cycle. Next state is IDLE.
- `lines_cleared` updates when DONE is entered and holds until the next pass enters SCAN. During a pass it is not guaranteed valid.
- Writes always target a row at or below `src`, so every write lands on a row that has already been read. No read-after-write hazard exists.
- `start` is ignored in SCAN, FILL and DONE. No queuing.
- Pointer decrements never go below 0. State exits occur before any wrap.

## Timing

- Reset values: state IDLE, `busy`=0, `done`=0, `lines_cleared`=0, `pf_wr_en`=0, `pf_rd_row`=0, `pf_wr_row`=0, `pf_wr_data`=0.
- `start` is sampled at edge E0. SCAN occupies the ROWS cycles after E0, and FILL occupies the next N cycles, where N = `lines_cleared`.
- DONE occupies cycle ROWS+N+1 counted from E0; `busy` is low during DONE.
- `busy` is high for exactly ROWS+N cycles. Total latency from `start` to `done` is ROWS+N+1 cycles.
- `pf_wr_*` outputs are combinational from the current state, pointers and `pf_rd_data`.
- `rst` asserted mid-pass returns the block to IDLE immediately, with all outputs at their reset values. The playfield is left partially compacted; recovery is the game FSM's responsibility.

## Configuration

- Macro: `LINE_CLEAR_SKIP_REDUNDANT_WR_EN`.
- **Defined:** in SCAN, a non-full row with `src`==`dst` (no full row found yet) produces `pf_wr_en`=0. This saves storage write energy. Pointer and state timing are unchanged.
- **Undefined:** every non-full SCAN row produces a write, including writes of a row onto itself.

## Test plan

- **Empty playfield:** `start` -> `busy` high for 20 cycles, `done` at cycle 21, `lines_cleared`=0. Writes: 0 with the macro, 20 without.
- **Rows 18 and 19 all GARBAGE, row 17 holding T at column 0 only:** `lines_cleared`=2, `done` at cycle 23. Row 19 ends with T at column 0; rows 0 and 1 are written BLANK.
- **Row 19 filled except GHOST at column 9:** row is not cleared, `lines_cleared`=0.
- **Full rows 13, 15, 17, 19, all other rows holding one tile at column 5:** `lines_cleared`=4 and rows 16–19 end non-full. With the macro, row 19 is first written from source row 18.
- **All 20 rows full:** `lines_cleared`=20, 20 FILL writes for rows 19 down to 0, `done` at cycle 41.
- **Protocol:**
  - `start` pulsed during SCAN -> ignored; the pass count and timing are unchanged.
  - `rst` asserted at SCAN cycle 5 -> `busy`=0, `pf_wr_en`=0 and `lines_cleared`=0 in the same cycle.
  - A new `start` after release -> a full 20-cycle pass.

Source files
------------

// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: drops full playfield rows, compacts and back-fills blanks.
// Option: LINE_CLEAR_SKIP_REDUNDANT_WR_EN suppresses self-writes before the first full row.
module line_clear_ctrl #(
  parameter int ROWS = 20,
  parameter int COLS = 10,
  parameter int RW   = $clog2(ROWS),
  parameter int CW   = $clog2(ROWS+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   lines_cleared,
  output logic [RW-1:0]   pf_rd_row,
  input  logic [4*COLS-1:0] pf_rd_data,
  output logic            pf_wr_en,
  output logic [RW-1:0]   pf_wr_row,
  output logic [4*COLS-1:0] pf_wr_data
);

  // Tile codes that leave a cell open
  localparam logic [3:0] BLANK = 4'd0;
  localparam logic [3:0] GHOST = 4'd9;

  typedef enum logic [1:0] {IDLE, SCAN, FILL, DONE} state_t;

  state_t        state, state_nx;
  logic [RW-1:0] src, src_nx;
  logic [RW-1:0] dst, dst_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          full;

  always_comb begin
    full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (pf_rd_data[4*c +: 4] == BLANK ||
          pf_rd_data[4*c +: 4] == GHOST)
        full = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      src   <= '0;
      dst   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      src   <= src_nx;
      dst   <= dst_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    src_nx     = src;
    dst_nx     = dst;
    cnt_nx     = cnt;
    pf_rd_row  = '0;
    pf_wr_en   = 1'b0;
    pf_wr_row  = '0;
    pf_wr_data = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = SCAN;
          src_nx   = RW'(ROWS-1);
          dst_nx   = RW'(ROWS-1);
          cnt_nx   = '0;
        end
      end
      SCAN: begin
        pf_rd_row = src;
        if (full) begin
          cnt_nx = cnt + CW'(1);
        end else begin
`ifdef LINE_CLEAR_SKIP_REDUNDANT_WR_EN
          pf_wr_en = (src != dst);
`else
          pf_wr_en = 1'b1;
`endif
          pf_wr_row  = dst;
          pf_wr_data = pf_rd_data;
          if (dst != '0)
            dst_nx = dst - RW'(1);
        end
        if (src != '0)
          src_nx = src - RW'(1);
        else
          state_nx = (cnt_nx != '0) ? FILL : DONE;
      end
      FILL: begin
        pf_wr_en  = 1'b1;
        pf_wr_row = dst;
        if (dst != '0)
          dst_nx = dst - RW'(1);
        else
          state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign busy          = (state == SCAN) || (state == FILL);
  assign done          = (state == DONE);
  assign lines_cleared = cnt;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Randomised + directed bench for line_clear_ctrl against a row-queue model.
module tb_line_clear_ctrl;

  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(ROWS+1);
  localparam int DW   = 4*COLS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done;
  logic [CW-1:0] lines_cleared;
  logic [RW-1:0] pf_rd_row, pf_wr_row;
  logic [DW-1:0] pf_rd_data, pf_wr_data;
  logic          pf_wr_en;

  logic [DW-1:0] pf      [ROWS];
  logic [DW-1:0] init_pf [ROWS];
  logic [DW-1:0] exp_pf  [ROWS];
  logic          load = 1'b0;
  int            exp_n, exp_wr;
  int            nvec = 0;
  int            nerr = 0;

  always #5 clk = ~clk;

  line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done),
    .lines_cleared(lines_cleared),
    .pf_rd_row(pf_rd_row), .pf_rd_data(pf_rd_data),
    .pf_wr_en(pf_wr_en), .pf_wr_row(pf_wr_row),
    .pf_wr_data(pf_wr_data)
  );

  assign pf_rd_data = pf[pf_rd_row];

  always @(posedge clk) begin
    if (load)
      pf <= init_pf;
    else if (pf_wr_en)
      pf[pf_wr_row] <= pf_wr_data;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_full(input logic [DW-1:0] r);
    logic [3:0] t;
    for (int c = 0; c < COLS; c++) begin
      t = r[4*c +: 4];
      if (t == 4'd0 || t == 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [DW-1:0] rand_row(input bit make_full);
    logic [DW-1:0] r;
    int k;
    for (int c = 0; c < COLS; c++)
      r[4*c +: 4] = make_full ? 4'($urandom_range(1, 8))
                              : 4'($urandom_range(0, 9));
    if (!make_full) begin
      k = $urandom_range(0, COLS-1);
      r[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'd9;
    end
    return r;
  endfunction

  // Reference: survivors keep bottom-up order, blanks fill the top
  task automatic build_exp();
    logic [DW-1:0] q[$];
    bit seen_full = 1'b0;
    exp_n  = 0;
    exp_wr = 0;
    for (int r = ROWS-1; r >= 0; r--) begin
      if (is_full(init_pf[r])) begin
        exp_n++;
        seen_full = 1'b1;
      end else begin
        q.push_back(init_pf[r]);
`ifdef LINE_CLEAR_SKIP_REDUNDANT_WR_EN
        if (seen_full) exp_wr++;
`else
        exp_wr++;
`endif
      end
    end
    exp_wr += exp_n;
    for (int i = 0; i < ROWS; i++)
      exp_pf[ROWS-1-i] = (i < q.size()) ? q[i] : '0;
  endtask

  task automatic load_pf();
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  task automatic run_pass(input bit poke);
    int busy_n = 0;
    int wr_n = 0;
    int done_k = -1;
    load_pf();
    build_exp();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      start = (poke && k == 5);
      if (busy) busy_n++;
      if (pf_wr_en) wr_n++;
      if (done) begin
        done_k = k;
        break;
      end
    end
    start = 1'b0;
    if (done_k < 0) chk("done_timeout", 0, 1);
    chk("lines", lines_cleared, exp_n);
    chk("done_cycle", done_k, ROWS + exp_n + 1);
    chk("busy_cycles", busy_n, ROWS + exp_n);
    chk("writes", wr_n, exp_wr);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("lines_hold", lines_cleared, exp_n);
    for (int r = 0; r < ROWS; r++)
      chk($sformatf("row%0d", r), pf[r], exp_pf[r]);
  endtask

  initial begin
    for (int r = 0; r < ROWS; r++) init_pf[r] = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lines", lines_cleared, 0);
    chk("rst_wr_en", pf_wr_en, 0);
    chk("rst_rd_row", pf_rd_row, 0);
    chk("rst_wr_row", pf_wr_row, 0);
    chk("rst_wr_data", pf_wr_data, 0);
    @(negedge clk) rst = 1'b0;

    // Empty playfield
    run_pass(1'b0);

    // Two garbage rows under a lone T
    for (int r = 0; r < ROWS; r++) init_pf[r] = '0;
    init_pf[18] = {COLS{4'h8}};
    init_pf[19] = {COLS{4'h8}};
    init_pf[17] = DW'(3);
    run_pass(1'b0);

    // Ghost keeps the row alive
    for (int r = 0; r < ROWS; r++) init_pf[r] = '0;
    init_pf[19] = {4'h9, {(COLS-1){4'h1}}};
    run_pass(1'b0);

    // Interleaved full rows
    for (int r = 0; r < ROWS; r++)
      init_pf[r] = (r == 13 || r == 15 || r == 17 || r == 19)
                   ? {COLS{4'h8}} : DW'(1) << 20;
    run_pass(1'b0);

    // Whole board full
    for (int r = 0; r < ROWS; r++) init_pf[r] = rand_row(1'b1);
    run_pass(1'b0);

    // Start pulsed mid-scan must be ignored
    for (int r = 0; r < ROWS; r++)
      init_pf[r] = rand_row($urandom_range(0, 2) == 0);
    run_pass(1'b1);

    // Reset in scan cycle 5
    for (int r = 0; r < ROWS; r++) init_pf[r] = rand_row(1'b1);
    load_pf();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 5; k++) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_wr_en", pf_wr_en, 0);
    chk("midrst_lines", lines_cleared, 0);
    chk("midrst_done", done, 0);
    @(negedge clk) rst = 1'b0;
    for (int r = 0; r < ROWS; r++) init_pf[r] = '0;
    run_pass(1'b0);

    // Random boards
    for (int t = 0; t < 30; t++) begin
      for (int r = 0; r < ROWS; r++)
        init_pf[r] = rand_row($urandom_range(0, 3) == 0);
      run_pass($urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
